alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 3-operand ALU (ADD/OR/AND, 1-cycle registered latency) among NUM_REQ requesters.
//  Accepts one op at a time, drives the ALU issue pulse, waits for the ALU valid (with timeout), returns tagged results.
//  Sits between requester command ports and the shared ALU; result path has valid/ready backpressure.
// PARAMETERS
//  NUM_REQ  4  number of requesters (>=2); ID_W = $clog2(NUM_REQ) is a localparam
//  OP_W     2  operand width of a/b/c
//  RES_W    4  ALU result width of e/f/g
//  TIMEOUT  4  max WAIT cycles for alu_vld before error completion (>=1)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              reset, asynchronous, active-low
//  req_valid  in   NUM_REQ        per-requester request valid
//  req_ready  out  NUM_REQ        per-requester accept (one-hot, at most one bit high)
//  req_cntrl  in   NUM_REQ*2      op per requester: 0 ADD, 1 OR, 2 AND, 3 reserved
//  req_a/b/c  in   NUM_REQ*OP_W   operands per requester, packed, index i at [i*OP_W +: OP_W]
//  alu_invld  out  1              ALU issue strobe
//  alu_cntrl  out  2              ALU op
//  alu_a/b/c  out  OP_W           ALU operands
//  alu_vld    in   1              ALU result valid
//  alu_e/f/g  in   RES_W          ALU results (a,b / b,c / c,a)
//  rsp_valid  out  1              response valid
//  rsp_ready  in   1              response consumer ready
//  rsp_id     out  ID_W           index of requester owning the response
//  rsp_e/f/g  out  RES_W          response results
//  rsp_err    out  1              1 = reserved op or ALU timeout; results forced 0
//  busy       out  1              state != IDLE
// BEHAVIOUR
//  Reset (rst low, async): state IDLE, rr_ptr=0, timeout cnt=0; all outputs 0; stored op/results 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE; reserved op: IDLE -> RESP.
//  IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ. req_ready[grant]=1 (combinational) this cycle only.
//   The accept cycle captures id, cntrl, a, b, c into op regs; rr_ptr <= (grant+1) mod NUM_REQ.
//  ISSUE: alu_invld=1 for exactly one cycle, alu_cntrl/a/b/c from op regs (registered, stable, 0 outside ISSUE); -> WAIT, cnt=0.
//  WAIT: alu_vld=1 -> capture e/f/g, err=0, -> RESP. Else cnt++; when cnt reaches TIMEOUT-1 without vld -> RESP with err=1, results 0.
//  RESP: rsp_valid=1; rsp_id/e/f/g/err held stable until rsp_valid&&rsp_ready; then -> IDLE. No new accept while not in IDLE.
//  Timing: accept at T, alu_invld at T+1, alu_vld expected at T+2, rsp_valid from T+3. Reserved op: rsp_valid at T+1.
//   Peak throughput is one op per 4 cycles with rsp_ready tied high.
//  Requester rule: req_* stable while req_valid && !req_ready; dropping valid before accept is legal (request withdrawn).
//  alu_vld outside WAIT (spurious/late after timeout) is ignored and not stored.
//  ADD results are zero-extended sums of the 2-bit operands, max 6; width is handled by the ALU, passed through unchanged.
//  Reset mid-operation: abort immediately, no response emitted; ALU vld arriving after reset is ignored (IDLE).
//  No req_valid in IDLE: stay IDLE, rr_ptr unchanged. Single requester: granted back-to-back each IDLE visit.
// STRUCTURE
//  Package alu_arb_pkg: typedef enum logic[1:0] {OP_ADD=0, OP_OR=1, OP_AND=2, OP_RSVD=3} alu_op_e;
//   typedef enum logic[1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} arb_state_e.
//  Sub-module rr_arbiter #(N): combinational, inputs req[N] + ptr, outputs one-hot gnt[N], gnt_idx, any.
//  Top holds FSM, op/result registers, timeout counter, rr_ptr.
// TESTING
//  Reset: rst low mid-WAIT -> all outputs 0 at once; later alu_vld pulse -> no rsp_valid; rr_ptr=0.
//  Req0 ADD a=3,b=2,c=1, ALU model 1-cycle -> alu_invld at T+1, rsp_valid T+3, id=0, e=5, f=3, g=4, err=0.
//  All 4 valid, rsp_ready=1 -> grant order 0,1,2,3,0; reqs 1,3 only -> 1,3,1,3.
//  Req2 cntrl=3 -> no alu_invld, rsp_valid at T+1, id=2, err=1, e/f/g=0.
//  ALU model never asserts vld, TIMEOUT=4 -> rsp err=1 after 4 WAIT cycles; next op proceeds normally.
//  rsp_ready low 5 cycles with OR a=1,b=2,c=2 -> rsp held (e=3, f=2, g=3), req_ready stays 0, accept resumes after handshake.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types for the ALU share arbiter
// Purpose: op encoding seen on req_cntrl/alu_cntrl and the sequencer state set.
// Ports: none (package).
package alu_arb_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_OR   = 2'd1,
    OP_AND  = 2'd2,
    OP_RSVD = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin request picker
// Purpose: picks the first asserted request at or after i_ptr, wrapping modulo N.
// Ports:
//   i_req     in  N     request vector
//   i_ptr     in  ID_W  highest-priority index this cycle
//   o_gnt     out N     one-hot grant (all zero when no request)
//   o_gnt_idx out ID_W  index of the granted request
//   o_any     out 1     at least one request present
module rr_arbiter #(
  parameter int N = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_gnt_idx,
  output logic            o_any
);

  // Scan offsets from farthest to nearest so the nearest hit to i_ptr
  // overwrites any earlier one; avoids a priority flag in the loop.
  always_comb begin : scan
    int w_j;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    w_j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_gnt_idx  = ID_W'(w_j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one ALU among requesters
// Purpose: accepts one op at a time, issues it to the ALU, waits for the result
//   (bounded by TIMEOUT) and returns a tagged response with backpressure.
// Ports:
//   clk, rst                  clock / async active-low reset
//   req_valid/req_ready       per-requester handshake (ready one-hot, IDLE only)
//   req_cntrl/req_a/b/c       packed per-requester op and operands
//   alu_invld/alu_cntrl/a/b/c registered ALU issue, zero outside ISSUE
//   alu_vld/alu_e/f/g         ALU result return
//   rsp_valid/rsp_ready       response handshake
//   rsp_id/rsp_e/f/g/rsp_err  response payload, zero while rsp_valid is low
//   busy                      sequencer not idle
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int OP_W    = 2,
  parameter int RES_W   = 4,
  parameter int TIMEOUT = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*2-1:0]    req_cntrl,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_c,
  output logic                    alu_invld,
  output logic [1:0]              alu_cntrl,
  output logic [OP_W-1:0]         alu_a,
  output logic [OP_W-1:0]         alu_b,
  output logic [OP_W-1:0]         alu_c,
  input  logic                    alu_vld,
  input  logic [RES_W-1:0]        alu_e,
  input  logic [RES_W-1:0]        alu_f,
  input  logic [RES_W-1:0]        alu_g,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_e,
  output logic [RES_W-1:0]        rsp_f,
  output logic [RES_W-1:0]        rsp_g,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_alu_invld;
  logic [1:0]        r_alu_cntrl;
  logic [OP_W-1:0]   r_alu_a;
  logic [OP_W-1:0]   r_alu_b;
  logic [OP_W-1:0]   r_alu_c;
  logic [RES_W-1:0]  r_e;
  logic [RES_W-1:0]  r_f;
  logic [RES_W-1:0]  r_g;
  logic              r_err;

  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_any;
  logic [ID_W-1:0]    w_next_ptr;
  alu_op_e            w_req_op;
  logic [OP_W-1:0]    w_req_a;
  logic [OP_W-1:0]    w_req_b;
  logic [OP_W-1:0]    w_req_c;
  logic               w_timeout;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req     (req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_req_op   = alu_op_e'(req_cntrl[w_gnt_idx*2 +: 2]);
  assign w_req_a    = req_a[w_gnt_idx*OP_W +: OP_W];
  assign w_req_b    = req_b[w_gnt_idx*OP_W +: OP_W];
  assign w_req_c    = req_c[w_gnt_idx*OP_W +: OP_W];
  assign w_next_ptr = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  // Last WAIT cycle reached with no result: give up on this op.
  assign w_timeout  = (r_state == S_WAIT) && !alu_vld && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          // Gate with rst so no grant is shown while reset is asserted.
          req_ready = rst ? w_gnt : '0;
          w_next    = (w_req_op == OP_RSVD) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (alu_vld || w_timeout) w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The alu_* registers double as the captured op: they are loaded on accept,
  // presented for the single ISSUE cycle and cleared afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_alu_invld <= 1'b0;
      r_alu_cntrl <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_c     <= '0;
      r_e         <= '0;
      r_f         <= '0;
      r_g         <= '0;
      r_err       <= 1'b0;
    end else begin
      r_alu_invld <= 1'b0;
      r_alu_cntrl <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_c     <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id     <= w_gnt_idx;
            r_rr_ptr <= w_next_ptr;
            r_e      <= '0;
            r_f      <= '0;
            r_g      <= '0;
            r_err    <= (w_req_op == OP_RSVD);
            if (w_req_op != OP_RSVD) begin
              r_alu_invld <= 1'b1;
              r_alu_cntrl <= w_req_op;
              r_alu_a     <= w_req_a;
              r_alu_b     <= w_req_b;
              r_alu_c     <= w_req_c;
            end
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (alu_vld) begin
            r_e   <= alu_e;
            r_f   <= alu_f;
            r_g   <= alu_g;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_invld = r_alu_invld;
  assign alu_cntrl = r_alu_cntrl;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_c     = r_alu_c;

  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = rsp_valid ? r_id : '0;
  assign rsp_e     = rsp_valid ? r_e : '0;
  assign rsp_f     = rsp_valid ? r_f : '0;
  assign rsp_g     = rsp_valid ? r_g : '0;
  assign rsp_err   = rsp_valid & r_err;
  assign busy      = (r_state != S_IDLE);

endmodule
